// File: rtl/ysyx_220066_mem_arbiter.sv
// ysyx_220066_mem_arbiter: round-robin I/D arbiter for one memory read port with response timeout
module ysyx_220066_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_error,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_error,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_error
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  state_t state, state_n;
  logic owner, last_grant, d_win, err_q, timed_out, tmo;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0] cnt;
  // owner/last_grant: 1 = D side; on a tie the side not granted last time wins
  assign d_win    = d_req && (!i_req || !last_grant);
  assign i_ready  = state == IDLE && i_req && !d_win;
  assign d_ready  = state == IDLE && d_req && d_win;
  assign tmo      = TIMEOUT != 0 && cnt == TLIM;
  assign m_req    = state == ISSUE;
  assign m_addr   = addr_q;
  assign i_rvalid = state == RESP && !owner;
  assign d_rvalid = state == RESP && owner;
  assign i_rdata  = data_q;
  assign d_rdata  = data_q;
  assign i_error  = err_q;
  assign d_error  = err_q;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = (i_req || d_req) ? ISSUE : IDLE;
      ISSUE:   state_n = m_ready ? WAIT : ISSUE;
      WAIT:    state_n = (m_rvalid || tmo) ? RESP : WAIT;
      RESP:    state_n = timed_out ? DRAIN : IDLE;
      DRAIN:   state_n = m_rvalid ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      timed_out  <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (i_req || d_req)) begin
        addr_q     <= d_win ? d_addr : i_addr;
        owner      <= d_win;
        last_grant <= d_win;
      end
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      // a response arriving on the timeout cycle takes priority over the forced error
      if (state == WAIT && (m_rvalid || tmo)) begin
        data_q    <= m_rvalid ? m_rdata : '0;
        err_q     <= m_rvalid ? m_error : 1'b1;
        timed_out <= !m_rvalid;
      end
    end
  end
endmodule
